// File: rtl/axi4_slave_mult_wrapper.sv
// AXI4-style slave around an iterative shift-add multiplier: burst writes load
// operands a/b, a good write to b starts a multiply, bursts read the product.
module axi4_slave_mult_wrapper #(
  parameter int SZ  = 32,
  parameter int ASZ = 2,
  parameter int DSZ = 8
) (
  input  logic             _rst,
  input  logic             clk,
  input  logic [ASZ-1:0]   awaddr,
  input  logic             awvalid,
  output logic             awready,
  input  logic [DSZ-1:0]   wdata,
  input  logic             wvalid,
  input  logic             wlast,
  output logic             wready,
  output logic             bresp,
  output logic             bvalid,
  input  logic             bready,
  input  logic [ASZ-1:0]   araddr,
  input  logic             arvalid,
  output logic             arready,
  output logic [DSZ-1:0]   rdata,
  output logic             rvalid,
  output logic             rlast,
  output logic             rresp,
  input  logic             rready,
  output logic [SZ-1:0]    a_q,
  output logic [SZ-1:0]    b_q,
  output logic [2*SZ-1:0]  res,
  output logic             busy,
  output logic [1:0]       w_state_dbg,
  output logic             r_state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid and ready
  // are both high; valid never waits on ready, and ready may depend on state.
  localparam int NB  = SZ / DSZ;
  localparam int CW  = $clog2(NB + 1);
  localparam int RB  = 2 * SZ / DSZ;
  localparam int RCW = $clog2(RB);
  localparam int MCW = $clog2(SZ);
  localparam logic [CW-1:0] NB_C   = CW'(NB);
  localparam logic [CW-1:0] LAST_C = CW'(NB - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [ASZ-1:0]   w_addr;
  logic [CW-1:0]    w_cnt;
  logic             w_err;
  logic             aw_hs, w_hs, start;
  logic             ar_hs, r_hs;
  logic [2*SZ-1:0]  r_snap;
  logic [RCW-1:0]   r_cnt;
  logic [2*SZ-1:0]  m_acc, m_cand, m_sum;
  logic [SZ-1:0]    m_plier;
  logic [MCW-1:0]   m_cnt;

  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

  // ---------------- write channel ----------------
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready = ~busy;
        if (awvalid && !busy) w_next = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && wlast) w_next = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = ~w_err;
        if (bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;
  assign start = bvalid && bready && (w_addr == ASZ'(1)) && !w_err;

  // Beat counter saturates at NB so any surplus beat is both dropped and flagged.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      w_addr <= '0;
      w_cnt  <= '0;
      w_err  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      if (aw_hs) begin
        w_addr <= awaddr;
        w_cnt  <= '0;
        w_err  <= (awaddr > ASZ'(1));
      end
      if (w_hs) begin
        for (int k = 0; k < NB; k++) begin
          if (w_cnt == CW'(k)) begin
            if (w_addr == ASZ'(0)) a_q[k*DSZ +: DSZ] <= wdata;
            if (w_addr == ASZ'(1)) b_q[k*DSZ +: DSZ] <= wdata;
          end
        end
        if (w_cnt != NB_C) w_cnt <= w_cnt + CW'(1);
        if (w_cnt == NB_C || (wlast && w_cnt != LAST_C)) w_err <= 1'b1;
      end
    end
  end

  // ---------------- multiplier ----------------
  assign m_sum = m_acc + (m_plier[0] ? m_cand : '0);

  // One partial product per busy cycle; res only moves on the final iteration.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      busy    <= 1'b0;
      res     <= '0;
      m_acc   <= '0;
      m_cand  <= '0;
      m_plier <= '0;
      m_cnt   <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      m_acc   <= '0;
      m_cand  <= {{SZ{1'b0}}, a_q};
      m_plier <= b_q;
      m_cnt   <= '0;
    end else if (busy) begin
      m_acc   <= m_sum;
      m_cand  <= m_cand << 1;
      m_plier <= m_plier >> 1;
      m_cnt   <= m_cnt + MCW'(1);
      if (m_cnt == MCW'(SZ - 1)) begin
        busy <= 1'b0;
        res  <= m_sum;
      end
    end
  end

  // ---------------- read channel ----------------
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    arready = 1'b0;
    rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready = ~busy;
        if (arvalid && !busy) r_next = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        if (rready && rlast) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_hs = arvalid && arready;
  assign r_hs  = rvalid && rready;

  // rdata/rlast are registered and only move on a beat handshake, so they stay
  // stable while the master stalls.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_snap <= '0;
      r_cnt  <= '0;
      rdata  <= '0;
      rlast  <= 1'b0;
      rresp  <= 1'b0;
    end else if (ar_hs) begin
      r_snap <= res >> DSZ;
      r_cnt  <= '0;
      rresp  <= (araddr == ASZ'(0));
      rdata  <= (araddr == ASZ'(0)) ? res[DSZ-1:0] : '0;
      rlast  <= 1'b0;
    end else if (r_hs) begin
      if (rlast) begin
        rdata <= '0;
        rlast <= 1'b0;
        rresp <= 1'b0;
      end else begin
        r_snap <= r_snap >> DSZ;
        rdata  <= rresp ? r_snap[DSZ-1:0] : '0;
        r_cnt  <= r_cnt + RCW'(1);
        rlast  <= (r_cnt == RCW'(RB - 2));
      end
    end
  end

endmodule

// File: tb/tb_axi4_slave_mult_wrapper.sv
// Directed bench for axi4_slave_mult_wrapper: a table of operand/product
// vectors plus hand-written sequences for error, stall, busy and reset cases.
module tb_axi4_slave_mult_wrapper;

  localparam int SZ  = 32;
  localparam int ASZ = 2;
  localparam int DSZ = 8;

  logic              _rst, clk;
  logic [ASZ-1:0]    awaddr, araddr;
  logic              awvalid, awready, wvalid, wlast, wready;
  logic [DSZ-1:0]    wdata, rdata;
  logic              bresp, bvalid, bready;
  logic              arvalid, arready, rvalid, rlast, rresp, rready;
  logic [SZ-1:0]     a_q, b_q;
  logic [2*SZ-1:0]   res;
  logic              busy;
  logic [1:0]        w_state_dbg;
  logic              r_state_dbg;

  int n_vec = 0;
  int n_err = 0;

  axi4_slave_mult_wrapper #(.SZ(SZ), .ASZ(ASZ), .DSZ(DSZ)) dut (
    ._rst(_rst), .clk(clk),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rresp(rresp), .rready(rready),
    .a_q(a_q), .b_q(b_q), .res(res), .busy(busy),
    .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_awready"}, awready, 1);
    check({tag, "_wready"},  wready, 0);
    check({tag, "_bvalid"},  bvalid, 0);
    check({tag, "_bresp"},   bresp, 0);
    check({tag, "_arready"}, arready, 1);
    check({tag, "_rvalid"},  rvalid, 0);
    check({tag, "_rdata"},   rdata, 0);
    check({tag, "_rlast"},   rlast, 0);
    check({tag, "_rresp"},   rresp, 0);
    check({tag, "_a_q"},     a_q, 0);
    check({tag, "_b_q"},     b_q, 0);
    check({tag, "_res"},     res, 0);
    check({tag, "_busy"},    busy, 0);
  endtask

  // driver tasks: each starts and ends on a falling edge
  task automatic aw_send(input logic [ASZ-1:0] addr);
    int n;
    awaddr = addr; awvalid = 1'b1; n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    check("awready_seen", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [DSZ-1:0] d, input logic last);
    int n;
    wdata = d; wlast = last; wvalid = 1'b1; n = 0;
    while (!wready && n < 200) begin @(negedge clk); n++; end
    check("wready_seen", wready, 1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_recv(input logic exp_bresp);
    int n;
    bready = 1'b1; n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    check("bvalid_seen", bvalid, 1);
    check("bresp", bresp, exp_bresp);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic w_beats(input logic [31:0] val, input int nbeats);
    for (int k = 0; k < nbeats; k++)
      w_beat((k < 4) ? val[k*8 +: 8] : 8'hEE, k == nbeats - 1);
  endtask

  task automatic write_burst(input logic [ASZ-1:0] addr, input logic [31:0] val,
                             input int nbeats, input logic exp_bresp);
    aw_send(addr);
    w_beats(val, nbeats);
    b_recv(exp_bresp);
  endtask

  task automatic ar_send(input logic [ASZ-1:0] addr);
    int n;
    araddr = addr; arvalid = 1'b1; n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    check("arready_seen", arready, 1);
    check("ar_accept_not_busy", busy, 0);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic read_beats(input logic [63:0] exp_val, input logic exp_resp, input logic toggle);
    logic [7:0] eb;
    for (int j = 0; j < 8; j++) begin
      eb = exp_resp ? exp_val[j*8 +: 8] : 8'h00;
      if (toggle) begin
        rready = 1'b0;
        @(negedge clk);
        check("rdata_held", rdata, eb);
      end
      rready = 1'b1;
      check("rvalid", rvalid, 1);
      check("rdata", rdata, eb);
      check("rlast", rlast, j == 7);
      check("rresp", rresp, exp_resp);
      @(negedge clk);
      rready = 1'b0;
    end
    check("r_done_idle", rvalid, 0);
  endtask

  task automatic wait_busy(output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin cyc++; @(negedge clk); end
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  vec_t vecs[8];
  int   cyc;

  initial begin
    vecs[0] = '{32'h00000003, 32'h00000005, 64'h000000000000000F};
    vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
    vecs[2] = '{32'h00000000, 32'h12345678, 64'h0000000000000000};
    vecs[3] = '{32'h12345678, 32'h00000010, 64'h0000000123456780};
    vecs[4] = '{32'h80000000, 32'h00000002, 64'h0000000100000000};
    vecs[5] = '{32'hFFFFFFFF, 32'h00000001, 64'h00000000FFFFFFFF};
    vecs[6] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
    vecs[7] = '{32'hDEADBEEF, 32'h00000100, 64'h000000DEADBEEF00};

    // reset block
    _rst = 1'b0;
    awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; wlast = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    _rst = 1'b1;
    @(negedge clk);

    // table-driven operand/product vectors
    for (int i = 0; i < 8; i++) begin
      write_burst(0, vecs[i].a, 4, 1'b1);
      check("a_q", a_q, vecs[i].a);
      write_burst(1, vecs[i].b, 4, 1'b1);
      check("b_q", b_q, vecs[i].b);
      check("busy_after_start", busy, 1);
      check("awready_while_busy", awready, 0);
      wait_busy(cyc);
      check("busy_cycles", cyc, 32);
      check("res", res, vecs[i].p);
      ar_send(0);
      read_beats(vecs[i].p, 1'b1, (i % 2) == 1);
    end

    // error bursts: invalid address, short burst, long burst
    write_burst(2, 32'h11223344, 4, 1'b0);
    check("a_q_after_addr2", a_q, 32'hDEADBEEF);
    check("b_q_after_addr2", b_q, 32'h00000100);
    repeat (3) @(negedge clk);
    check("no_mul_addr2", busy, 0);
    write_burst(1, 32'h0000CDEF, 2, 1'b0);
    check("b_q_short", b_q, 32'h0000CDEF);
    repeat (3) @(negedge clk);
    check("no_mul_short", busy, 0);
    check("res_kept_short", res, 64'h000000DEADBEEF00);
    write_burst(0, 32'hCAFEF00D, 5, 1'b0);
    check("a_q_long", a_q, 32'hCAFEF00D);

    // invalid read address with stalled master
    ar_send(1);
    read_beats(64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1);

    // AR while busy: accepted only after the new product lands
    write_burst(0, 32'd7, 4, 1'b1);
    write_burst(1, 32'd6, 4, 1'b1);
    arvalid = 1'b1; araddr = '0;
    check("arready_busy", arready, 0);
    ar_send(0);
    check("res_busy_read", res, 64'd42);
    read_beats(64'd42, 1'b1, 1'b0);

    // simultaneous AW and AR handshakes, channels then run concurrently
    awaddr = '0; awvalid = 1'b1; araddr = '0; arvalid = 1'b1;
    check("awready_coincide", awready, 1);
    check("arready_coincide", arready, 1);
    @(negedge clk);
    awvalid = 1'b0; arvalid = 1'b0;
    check("wready_coincide", wready, 1);
    fork
      read_beats(64'd42, 1'b1, 1'b1);
      begin
        w_beats(32'h00001000, 4);
        b_recv(1'b1);
      end
    join
    check("a_q_coincide", a_q, 32'h00001000);

    // reset mid-write (third beat in flight)
    aw_send(1);
    w_beat(8'h11, 1'b0);
    w_beat(8'h22, 1'b0);
    wdata = 8'h33; wvalid = 1'b1;
    #2 _rst = 1'b0;
    #1 check_reset_vals("rst_wr");
    @(negedge clk);
    wvalid = 1'b0; _rst = 1'b1;
    @(negedge clk);

    // reset mid-multiply
    write_burst(0, 32'd9, 4, 1'b1);
    write_burst(1, 32'd11, 4, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_mid_mul", busy, 1);
    #2 _rst = 1'b0;
    #1 check_reset_vals("rst_mul");
    @(negedge clk);
    _rst = 1'b1;
    repeat (40) @(negedge clk);
    check("no_partial_res", res, 0);

    // full sequence after reset
    write_burst(0, 32'h00001000, 4, 1'b1);
    write_burst(1, 32'h00000003, 4, 1'b1);
    wait_busy(cyc);
    check("busy_cycles_post_rst", cyc, 32);
    check("res_post_rst", res, 64'h0000000000003000);
    ar_send(0);
    read_beats(64'h0000000000003000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi4_slave_mult_wrapper.md
AXI4_SLAVE_MULT_WRAPPER -- requirements
Module: axi4_slave_mult_wrapper

Interface
REQ-001 Parameters, one per line: SZ, 32, operand width; ASZ, 2, address width; DSZ, 8, data beat width.
REQ-002 _rst  in  1  reset; asynchronous, active-low.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 awaddr  in  ASZ  write burst target; 0 = operand a, 1 = operand b, 2/3 = invalid.
REQ-005 awvalid  in  1; awready  out  1  write-address handshake.
REQ-006 wdata  in  DSZ; wvalid  in  1; wlast  in  1; wready  out  1  write data beats.
REQ-007 bresp  out  1  1 = ok, 0 = error; bvalid  out  1; bready  in  1  write response.
REQ-008 araddr  in  ASZ  read target; 0 = result, others invalid.
REQ-009 arvalid  in  1; arready  out  1  read-address handshake.
REQ-010 rdata  out  DSZ; rvalid  out  1; rlast  out  1; rresp  out  1 (1 = ok); rready  in  1  read data beats.
REQ-011 a_q, b_q  out  SZ each  stored operands; res  out  2*SZ  last completed product; busy  out  1  multiplier running.

Function
REQ-012 Write FSM states: W_IDLE (awready=1 unless busy), W_DATA (wready=1), W_RESP (bvalid=1); all other write outputs 0 in each state.
REQ-013 W_IDLE -> W_DATA on awvalid&awready; latch awaddr; clear beat counter and error flag.
REQ-014 Each wvalid&wready beat: beat k (0..3) writes byte k of the target register (beat 0 = bits 7:0, LSB first); beat counter increments; for invalid addresses, or for beats beyond the 4th, data is discarded.
REQ-015 Error flag sets when awaddr is 2 or 3, wlast arrives on a beat other than the 4th, or a 5th+ beat arrives.
REQ-016 W_DATA -> W_RESP on the beat carrying wlast; bresp = ~error flag.
REQ-017 W_RESP -> W_IDLE on bvalid&bready; bvalid is held until accepted.
REQ-018 On the same edge as REQ-017, if addr = 1 and bresp = 1, start the multiplier.
REQ-019 Multiplier is an iterative unsigned shift-add on internal copies of a_q/b_q latched at start.
REQ-020 Multiplier timing: busy = 1 starting the cycle after start, for exactly SZ (32) cycles; res updates to a*b (full 2*SZ bits, no truncation) on the edge that clears busy.
REQ-021 Later operand writes do not disturb a running product; awready = 0 while busy.
REQ-022 Read FSM states: R_IDLE (arready = ~busy), R_DATA (rvalid=1).
REQ-023 R_IDLE -> R_DATA on arvalid&arready; snapshot res into an 8-byte shift register; rresp = (araddr==0).
REQ-024 Beat data: rdata = snapshot byte j at beat j (LSB first), or 0 when rresp = 0; rlast = 1 only on beat 7 (8 beats total).
REQ-025 Beats advance only on rvalid&rready; rdata/rlast are held stable while rready = 0.
REQ-026 R_DATA -> R_IDLE on the rlast handshake.
REQ-027 Write FSM and read FSM operate concurrently and independently.
REQ-028 Within one cycle, AW and AR handshakes may coincide without interaction.

Reset
REQ-029 Reset value 0 for: a_q, b_q, res, busy, bvalid, bresp, wready, rvalid, rdata, rlast, rresp, and all counters and flags.
REQ-030 Reset value 1 for awready and arready; FSMs reset to W_IDLE and R_IDLE.
REQ-031 Reset asserted mid-burst or mid-multiply aborts immediately to the REQ-029/REQ-030 values; no partial result is kept.

Verification
REQ-032 Write a=3 (addr 0) then b=5 (addr 1), 4 beats each -> bresp=1 twice; busy for 32 cycles; res=0x000000000000000F.
REQ-033 a=b=0xFFFFFFFF, then read araddr 0 -> 8 beats 0x01,0x00,0x00,0x00,0xFE,0xFF,0xFF,0xFF; rlast on beat 8; rresp=1.
REQ-034 Write to awaddr 2, and a burst with wlast on beat 2 -> bresp=0; a_q/b_q unchanged after the addr-2 burst; no multiply after either burst.
REQ-035 AR issued while busy -> arready=0 until busy drops; returned data equals the new product.
REQ-036 rready toggled 1/0 per cycle during a read -> no beat lost or repeated; araddr=1 -> 8 beats with rdata=0, rresp=0.
REQ-037 _rst pulsed at beat 2 of a write and mid-multiply -> all outputs take reset values within the same cycle; next full a/b sequence yields the correct product.
